// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline control path: opcodes, ALU ops,
// PC-select and forwarding codes, and the per-stage control bundles.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       link;
        logic       alu_src;
        logic [2:0] alu_op;
    } ctrl_bundle_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic link;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;
    } wb_ctrl_t;

    // The younger producer (EX/MEM) takes precedence over MEM/WB.
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit)     sel = FWD_MEM;
        else if (wb_hit) sel = FWD_WB;
        else             sel = FWD_RF;
        return sel;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder: opcode to control bundle, destination
// register, source-usage flags and branch/jump class.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter bit EXT_ISA  = 1'b1
) (
    input  logic              valid,
    input  logic [5:0]        opcode,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output ctrl_bundle_t      ctrl,
    output logic [REG_AW-1:0] wr_reg,
    output logic              uses_rs,
    output logic              uses_rt,
    output logic              is_beq,
    output logic              is_bne,
    output logic              is_jump,
    output logic              illegal
);

    logic known;

    always_comb begin
        ctrl    = '0;
        wr_reg  = rt;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jump = 1'b0;
        known   = 1'b1;

        unique case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_op = ALU_FUNCT;
                wr_reg = rd; uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.alu_src = 1'b1;
                uses_rs = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1;
                uses_rs = 1'b1;
            end
            OP_ANDI: begin
                ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = ALU_AND; uses_rs = 1'b1;
            end
            OP_ORI: begin
                ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = ALU_OR; uses_rs = 1'b1; known = EXT_ISA;
            end
            OP_SLTI: begin
                ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = ALU_SLT; uses_rs = 1'b1; known = EXT_ISA;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = ALU_LUI; known = EXT_ISA;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALU_SUB; uses_rs = 1'b1; uses_rt = 1'b1; is_beq = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_op = ALU_SUB; uses_rs = 1'b1; uses_rt = 1'b1; is_bne = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.link = 1'b1;
                wr_reg = REG_AW'(LINK_REG); is_jump = 1'b1; known = EXT_ISA;
            end
            default: known = 1'b0;
        endcase

        // $0 is hard-wired; never let it look like a producer to the hazard logic.
        if (wr_reg == '0) ctrl.reg_write = 1'b0;

        illegal = valid && !known;
        if (!valid || !known) begin
            ctrl    = '0;
            wr_reg  = '0;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
            is_beq  = 1'b0;
            is_bne  = 1'b0;
            is_jump = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// 5-stage MIPS control path: ID decode, ID/EX, EX/MEM, MEM/WB control
// registers, stall/flush/redirect generation and EX forwarding selects.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter bit EXT_ISA  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regs_eq,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic [1:0]        pc_sel,
    output logic              id_illegal,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              wb_link,
    output logic [REG_AW-1:0] wb_wr_reg
);

    ctrl_bundle_t      id_ctrl;
    logic [REG_AW-1:0] id_wr_reg;
    logic              id_uses_rs, id_uses_rt, id_is_beq, id_is_bne, id_is_jump;
    logic              id_live;

    ctrl_bundle_t      ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_wr_reg_q, ex_wr_reg_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    mem_ctrl_t         mem_ctrl_q, mem_ctrl_d;
    logic [REG_AW-1:0] mem_wr_reg_q, mem_wr_reg_d;
    wb_ctrl_t          wb_ctrl_q, wb_ctrl_d;
    logic [REG_AW-1:0] wb_wr_reg_q, wb_wr_reg_d;

    logic load_use, branch_haz, hazard;
    logic ex_hits_src, mem_load_hits_src;
    logic mem_live, wb_live;

    ctrl_decode #(
        .REG_AW  (REG_AW),
        .LINK_REG(LINK_REG),
        .EXT_ISA (EXT_ISA)
    ) u_decode (
        .valid  (id_valid),
        .opcode (id_opcode),
        .rs     (id_rs),
        .rt     (id_rt),
        .rd     (id_rd),
        .ctrl   (id_ctrl),
        .wr_reg (id_wr_reg),
        .uses_rs(id_uses_rs),
        .uses_rt(id_uses_rt),
        .is_beq (id_is_beq),
        .is_bne (id_is_bne),
        .is_jump(id_is_jump),
        .illegal(id_illegal)
    );

    assign id_live = id_valid && !id_illegal;

    // Hazard detection and PC redirect; freeze outranks hazard outranks redirect.
    always_comb begin
        load_use = ex_ctrl_q.mem_read && (ex_wr_reg_q != '0) &&
                   ((id_uses_rs && (ex_wr_reg_q == id_rs)) ||
                    (id_uses_rt && (ex_wr_reg_q == id_rt)));
        ex_hits_src       = ex_ctrl_q.reg_write &&
                            ((ex_wr_reg_q == id_rs) || (ex_wr_reg_q == id_rt));
        mem_load_hits_src = mem_ctrl_q.mem_read &&
                            ((mem_wr_reg_q == id_rs) || (mem_wr_reg_q == id_rt));
        branch_haz = (id_is_beq || id_is_bne) && (ex_hits_src || mem_load_hits_src);
        hazard     = id_valid && (load_use || branch_haz);

        stall_if_id = ext_stall || hazard;
        pc_sel      = PC_SEQ;
        flush_if_id = 1'b0;
        if (!ext_stall && !hazard) begin
            if ((id_is_beq && id_regs_eq) || (id_is_bne && !id_regs_eq)) pc_sel = PC_BRANCH;
            else if (id_is_jump)                                         pc_sel = PC_JUMP;
            flush_if_id = (pc_sel != PC_SEQ);
        end
    end

    always_comb begin
        ex_ctrl_d    = ex_ctrl_q;
        ex_wr_reg_d  = ex_wr_reg_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        mem_ctrl_d   = mem_ctrl_q;
        mem_wr_reg_d = mem_wr_reg_q;
        wb_ctrl_d    = wb_ctrl_q;
        wb_wr_reg_d  = wb_wr_reg_q;
        if (!ext_stall) begin
            mem_ctrl_d   = '{reg_write:  ex_ctrl_q.reg_write,  mem_read: ex_ctrl_q.mem_read,
                             mem_write:  ex_ctrl_q.mem_write,
                             mem_to_reg: ex_ctrl_q.mem_to_reg, link:     ex_ctrl_q.link};
            mem_wr_reg_d = ex_wr_reg_q;
            wb_ctrl_d    = '{reg_write:  mem_ctrl_q.reg_write,
                             mem_to_reg: mem_ctrl_q.mem_to_reg, link: mem_ctrl_q.link};
            wb_wr_reg_d  = mem_wr_reg_q;
            if (hazard) begin
                ex_ctrl_d   = '0;
                ex_wr_reg_d = '0;
                ex_rs_d     = '0;
                ex_rt_d     = '0;
            end else begin
                ex_ctrl_d   = id_ctrl;
                ex_wr_reg_d = id_wr_reg;
                ex_rs_d     = id_live ? id_rs : '0;
                ex_rt_d     = id_live ? id_rt : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q    <= '0;
            ex_wr_reg_q  <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            mem_ctrl_q   <= '0;
            mem_wr_reg_q <= '0;
            wb_ctrl_q    <= '0;
            wb_wr_reg_q  <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_wr_reg_q  <= ex_wr_reg_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            mem_ctrl_q   <= mem_ctrl_d;
            mem_wr_reg_q <= mem_wr_reg_d;
            wb_ctrl_q    <= wb_ctrl_d;
            wb_wr_reg_q  <= wb_wr_reg_d;
        end
    end

    assign mem_live = mem_ctrl_q.reg_write && (mem_wr_reg_q != '0);
    assign wb_live  = wb_ctrl_q.reg_write && (wb_wr_reg_q != '0);
    assign ex_fwd_a = fwd_pick(mem_live && (mem_wr_reg_q == ex_rs_q),
                               wb_live && (wb_wr_reg_q == ex_rs_q));
    assign ex_fwd_b = fwd_pick(mem_live && (mem_wr_reg_q == ex_rt_q),
                               wb_live && (wb_wr_reg_q == ex_rt_q));

    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign mem_read      = mem_ctrl_q.mem_read;
    assign mem_write     = mem_ctrl_q.mem_write;
    assign wb_reg_write  = wb_ctrl_q.reg_write;
    assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
    assign wb_link       = wb_ctrl_q.link;
    assign wb_wr_reg     = wb_wr_reg_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (full and base ISA) checked every
// cycle against a behavioural pipeline model; directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ext_stall, id_valid, id_regs_eq;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [1:0] pc_sel;
        logic       illegal;
        logic [2:0] alu_op;
        logic       alu_src;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       mem_read;
        logic       mem_write;
        logic       wb_rw;
        logic       wb_m2r;
        logic       wb_link;
        logic [4:0] wb_wr;
    } out_t;

    out_t got [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       stall, flush, illegal, alu_src, mrd, mwr, wrw, wm2r, wlink;
        logic [1:0] pcs, fa, fb;
        logic [2:0] aop;
        logic [4:0] wwr;
        pipe_ctrl_unit #(.REG_AW(5), .LINK_REG(31), .EXT_ISA(g == 0)) dut (
            .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .id_valid(id_valid),
            .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
            .id_regs_eq(id_regs_eq), .stall_if_id(stall), .flush_if_id(flush),
            .pc_sel(pcs), .id_illegal(illegal), .ex_alu_op(aop), .ex_alu_src(alu_src),
            .ex_fwd_a(fa), .ex_fwd_b(fb), .mem_read(mrd), .mem_write(mwr),
            .wb_reg_write(wrw), .wb_mem_to_reg(wm2r), .wb_link(wlink), .wb_wr_reg(wwr)
        );
        assign got[g] = {stall, flush, pcs, illegal, aop, alu_src, fa, fb,
                         mrd, mwr, wrw, wm2r, wlink, wwr};
    end

    // Behavioural model: one record per in-flight instruction.
    typedef struct packed {
        bit       rw, mr, mw, m2r, link, src;
        bit [2:0] op;
        bit [4:0] wr, rs, rt;
    } rec_t;

    typedef struct packed {
        rec_t r;
        bit   urs, urt, beq, bne, jmp, known, illegal;
    } info_t;

    rec_t st [2][3];
    rec_t nx [2][3];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic info_t ref_decode(bit ext, bit v, bit [5:0] op,
                                         bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        info_t d;
        bit    wr_en;
        d = '0; wr_en = 1'b0; d.known = 1'b1; d.r.wr = rt;
        case (op)
            6'h00: begin wr_en = 1; d.r.m2r = 1; d.r.op = 3'd2; d.r.wr = rd; d.urs = 1; d.urt = 1; end
            6'h23: begin wr_en = 1; d.r.mr = 1; d.r.src = 1; d.urs = 1; end
            6'h2b: begin d.r.mw = 1; d.r.src = 1; d.urs = 1; d.urt = 1; end
            6'h08: begin wr_en = 1; d.r.m2r = 1; d.r.src = 1; d.urs = 1; end
            6'h0c: begin wr_en = 1; d.r.m2r = 1; d.r.src = 1; d.r.op = 3'd3; d.urs = 1; end
            6'h0d: if (ext) begin wr_en = 1; d.r.m2r = 1; d.r.src = 1; d.r.op = 3'd4; d.urs = 1; end
                   else d.known = 0;
            6'h0a: if (ext) begin wr_en = 1; d.r.m2r = 1; d.r.src = 1; d.r.op = 3'd5; d.urs = 1; end
                   else d.known = 0;
            6'h0f: if (ext) begin wr_en = 1; d.r.m2r = 1; d.r.src = 1; d.r.op = 3'd6; end
                   else d.known = 0;
            6'h04: begin d.r.op = 3'd1; d.urs = 1; d.urt = 1; d.beq = 1; end
            6'h05: begin d.r.op = 3'd1; d.urs = 1; d.urt = 1; d.bne = 1; end
            6'h02: d.jmp = 1;
            6'h03: if (ext) begin wr_en = 1; d.r.m2r = 1; d.r.link = 1; d.r.wr = 5'd31; d.jmp = 1; end
                   else d.known = 0;
            default: d.known = 0;
        endcase
        d.r.rw = wr_en && (d.r.wr != 5'd0);
        if (!(v && d.known)) begin
            d = '0;
            d.illegal = v;
        end else begin
            d.r.rs = rs;
            d.r.rt = rt;
        end
        return d;
    endfunction

    function automatic logic [1:0] ref_fwd(rec_t mem, rec_t wb, bit [4:0] src);
        if (mem.rw && mem.wr != 0 && mem.wr == src) return 2'b10;
        if (wb.rw && wb.wr != 0 && wb.wr == src)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic cmp(input int i, input out_t g, input out_t e);
        chk($sformatf("stall_if_id[%0d]", i),   32'(g.stall),   32'(e.stall));
        chk($sformatf("flush_if_id[%0d]", i),   32'(g.flush),   32'(e.flush));
        chk($sformatf("pc_sel[%0d]", i),        32'(g.pc_sel),  32'(e.pc_sel));
        chk($sformatf("id_illegal[%0d]", i),    32'(g.illegal), 32'(e.illegal));
        chk($sformatf("ex_alu_op[%0d]", i),     32'(g.alu_op),  32'(e.alu_op));
        chk($sformatf("ex_alu_src[%0d]", i),    32'(g.alu_src), 32'(e.alu_src));
        chk($sformatf("ex_fwd_a[%0d]", i),      32'(g.fwd_a),   32'(e.fwd_a));
        chk($sformatf("ex_fwd_b[%0d]", i),      32'(g.fwd_b),   32'(e.fwd_b));
        chk($sformatf("mem_read[%0d]", i),      32'(g.mem_read), 32'(e.mem_read));
        chk($sformatf("mem_write[%0d]", i),     32'(g.mem_write), 32'(e.mem_write));
        chk($sformatf("wb_reg_write[%0d]", i),  32'(g.wb_rw),   32'(e.wb_rw));
        chk($sformatf("wb_mem_to_reg[%0d]", i), 32'(g.wb_m2r),  32'(e.wb_m2r));
        chk($sformatf("wb_link[%0d]", i),       32'(g.wb_link), 32'(e.wb_link));
        chk($sformatf("wb_wr_reg[%0d]", i),     32'(g.wb_wr),   32'(e.wb_wr));
    endtask

    // Check every output of both instances at the falling edge and prepare next state.
    task automatic eval();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            info_t d;
            rec_t  ex, mem, wb;
            out_t  e;
            bit    lu, bh, hz;
            d   = ref_decode(i == 0, id_valid, id_opcode, id_rs, id_rt, id_rd);
            ex  = st[i][0];
            mem = st[i][1];
            wb  = st[i][2];
            lu  = ex.mr && ex.wr != 0 &&
                  ((d.urs && ex.wr == id_rs) || (d.urt && ex.wr == id_rt));
            bh  = (d.beq || d.bne) &&
                  ((ex.rw && (ex.wr == id_rs || ex.wr == id_rt)) ||
                   (mem.mr && (mem.wr == id_rs || mem.wr == id_rt)));
            hz  = id_valid && (lu || bh);
            e = '0;
            e.stall = ext_stall || hz;
            if (!ext_stall && !hz) begin
                if ((d.beq && id_regs_eq) || (d.bne && !id_regs_eq)) e.pc_sel = 2'b01;
                else if (d.jmp)                                      e.pc_sel = 2'b10;
                e.flush = (e.pc_sel != 2'b00);
            end
            e.illegal   = d.illegal;
            e.alu_op    = ex.op;
            e.alu_src   = ex.src;
            e.fwd_a     = ref_fwd(mem, wb, ex.rs);
            e.fwd_b     = ref_fwd(mem, wb, ex.rt);
            e.mem_read  = mem.mr;
            e.mem_write = mem.mw;
            e.wb_rw     = wb.rw;
            e.wb_m2r    = wb.m2r;
            e.wb_link   = wb.link;
            e.wb_wr     = wb.wr;
            cmp(i, got[i], e);

            nx[i] = st[i];
            if (!ext_stall) begin
                nx[i][2] = mem;
                nx[i][1] = ex;
                nx[i][0] = hz ? rec_t'('0) : d.r;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) st[i][k] = '0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (rst_n) st = nx;
        else clear_model();
    endtask

    task automatic drive(input bit v, input bit [5:0] op, input bit [4:0] rs,
                         input bit [4:0] rt, input bit [4:0] rd, input bit eq, input bit xs);
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_regs_eq = eq; ext_stall = xs;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(0, 6'h00, 0, 0, 0, 0, 0);
            eval();
            adv();
        end
    endtask

    bit [5:0] ops [14] = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h0c, 6'h0d, 6'h0a,
                           6'h0f, 6'h04, 6'h05, 6'h02, 6'h03, 6'h01, 6'h3f};

    initial begin
        rst_n = 1'b0;
        drive(0, 6'h00, 0, 0, 0, 0, 0);
        clear_model();
        @(posedge clk);
        #1;
        eval();
        adv();
        rst_n = 1'b1;

        // Load-use: lw $2 then add $3,$2,$4.
        idle(3);
        drive(1, 6'h23, 5'd1, 5'd2, 5'd0, 0, 0); eval(); adv();
        drive(1, 6'h00, 5'd2, 5'd4, 5'd3, 0, 0); eval();
        chk("lu_stall", 32'(got[0].stall), 32'd1);
        adv();
        eval();
        chk("lu_release", 32'(got[0].stall), 32'd0);
        chk("lu_bubble_src", 32'(got[0].alu_src), 32'd0);
        adv();
        drive(0, 6'h00, 0, 0, 0, 0, 0); eval();
        chk("lu_fwd_a", 32'(got[0].fwd_a), 32'd1);
        adv();

        // EX/MEM forward on port B, then the same with $0 as destination.
        idle(3);
        drive(1, 6'h00, 5'd1, 5'd1, 5'd5, 0, 0); eval(); adv();
        drive(1, 6'h00, 5'd6, 5'd5, 5'd7, 0, 0); eval(); adv();
        drive(0, 6'h00, 0, 0, 0, 0, 0); eval();
        chk("fwd_b_mem", 32'(got[0].fwd_b), 32'd2);
        adv();
        idle(3);
        drive(1, 6'h00, 5'd1, 5'd1, 5'd0, 0, 0); eval(); adv();
        drive(1, 6'h00, 5'd6, 5'd0, 5'd7, 0, 0); eval(); adv();
        drive(0, 6'h00, 0, 0, 0, 0, 0); eval();
        chk("fwd_b_r0", 32'(got[0].fwd_b), 32'd0);
        adv();
        eval();
        chk("wb_rw_r0", 32'(got[0].wb_rw), 32'd0);
        adv();

        // beq stalled on an EX producer, then resolves; bne with eq=1 does not redirect.
        idle(3);
        drive(1, 6'h08, 5'd0, 5'd8, 5'd0, 0, 0); eval(); adv();
        drive(1, 6'h04, 5'd8, 5'd9, 5'd0, 1, 0); eval();
        chk("beq_stall", 32'(got[0].stall), 32'd1);
        chk("beq_hold_pc", 32'(got[0].pc_sel), 32'd0);
        adv();
        eval();
        chk("beq_pc_sel", 32'(got[0].pc_sel), 32'd1);
        chk("beq_flush", 32'(got[0].flush), 32'd1);
        adv();
        drive(1, 6'h05, 5'd10, 5'd11, 5'd0, 1, 0); eval();
        chk("bne_pc_sel", 32'(got[0].pc_sel), 32'd0);
        chk("bne_flush", 32'(got[0].flush), 32'd0);
        adv();

        // jal: full ISA links to $31, base ISA flags it illegal.
        idle(3);
        drive(1, 6'h03, 5'd4, 5'd6, 5'd0, 0, 0); eval();
        chk("jal_pc_sel", 32'(got[0].pc_sel), 32'd2);
        chk("jal_flush", 32'(got[0].flush), 32'd1);
        chk("jal_illegal_base", 32'(got[1].illegal), 32'd1);
        adv();
        idle(2);
        drive(0, 6'h00, 0, 0, 0, 0, 0); eval();
        chk("jal_wb_wr", 32'(got[0].wb_wr), 32'd31);
        chk("jal_wb_link", 32'(got[0].wb_link), 32'd1);
        chk("jal_wb_rw", 32'(got[0].wb_rw), 32'd1);
        chk("jal_base_rw", 32'(got[1].wb_rw), 32'd0);
        adv();

        // Freeze during a load-use hazard, then release.
        idle(3);
        drive(1, 6'h23, 5'd1, 5'd2, 5'd0, 0, 0); eval(); adv();
        drive(1, 6'h00, 5'd2, 5'd4, 5'd3, 0, 1);
        repeat (3) begin
            eval();
            chk("frz_stall", 32'(got[0].stall), 32'd1);
            chk("frz_ex_src", 32'(got[0].alu_src), 32'd1);
            chk("frz_mem_rd", 32'(got[0].mem_read), 32'd0);
            adv();
        end
        ext_stall = 1'b0;
        eval();
        chk("rel_hazard", 32'(got[0].stall), 32'd1);
        adv();
        eval();
        chk("rel_stall", 32'(got[0].stall), 32'd0);
        chk("rel_bubble", 32'(got[0].alu_src), 32'd0);
        chk("rel_mem_rd", 32'(got[0].mem_read), 32'd1);
        adv();
        drive(0, 6'h00, 0, 0, 0, 0, 0); eval();
        chk("rel_add_ex", 32'(got[0].alu_op), 32'd2);
        adv();

        // Asynchronous reset with a load in MEM.
        idle(2);
        drive(1, 6'h23, 5'd1, 5'd2, 5'd0, 0, 0); eval(); adv();
        drive(0, 6'h00, 0, 0, 0, 0, 0); eval(); adv();
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("rst_mem_rd", 32'(got[0].mem_read), 32'd0);
        chk("rst_stall", 32'(got[0].stall), 32'd0);
        chk("rst_wb_wr", 32'(got[0].wb_wr), 32'd0);
        eval();
        adv();
        rst_n = 1'b1;

        // Random traffic on a small register set to provoke hazards.
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 99) < 85, ops[$urandom_range(0, 13)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 15);
            eval();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
